md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and handles MTHI/MTLO writes.
- Holds the architectural HI/LO registers and exposes them for MFHI/MFLO forwarding to E_ALU output selection.
- Drives a busy flag that the hazard unit combines with start to stall any md-class instruction sitting in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- E_md_start  input  1  high for one cycle when a MULT/MULTU/DIV/DIVU instruction is in E.
- E_md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; other values behave as NONE.
- E_rs_val  input  32  forwarded rs operand (dividend / multiplicand / MTxx source).
- E_rt_val  input  32  forwarded rt operand (divisor / multiplier).
- E_md_busy  output  1  operation in flight.
- E_HI  output  32  architectural HI.
- E_LO  output  32  architectural LO.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: E_md_busy=0, E_HI=0, E_LO=0, cycle counter=0, staged results=0. Reset during an operation aborts it; nothing is committed.
- States: IDLE and RUN; the counter is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits wide.
- Start, IDLE with E_md_start=1 and op in 1..4, at edge T:
  - Operands are latched and the full result is computed into staging registers (HI_s/LO_s).
  - Counter is loaded with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - State goes to RUN, so E_md_busy=1 from cycle T+1.
- RUN: counter decrements each edge. On the edge where the counter is 0, HI/LO <= HI_s/LO_s, busy falls, and the state returns to IDLE. Busy is therefore high for exactly N cycles; new HI/LO values are visible in the cycle after the last busy cycle.
- The start cycle itself does not assert busy. The hazard unit uses (E_md_start | E_md_busy).
- Arithmetic:
  - MULT: {HI,LO} = signed 32x32 -> 64.
  - MULTU: {HI,LO} = unsigned 32x32 -> 64.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, sign follows the dividend.
  - DIVU: LO/HI = unsigned quotient/remainder.
- MTHI/MTLO: when op is 5 or 6 and state is IDLE, HI or LO <= E_rs_val at that edge. No busy, no latency.
- E_md_start is valid only for op 1..4. E_md_start with op 5/6 is ignored.
- E_md_start or MTxx while RUN is ignored, and the in-flight operation continues unchanged. The hazard unit guarantees this does not occur; an assertion flags it.
- Unknown op: no state change.

Optional Feature:
- Macro: MD_DIV0_GUARD_EN.
- Defined: DIV/DIVU with E_rt_val==0 still runs the full DIV_CYCLES busy window, but commits nothing; HI/LO keep their prior values.
- Undefined: the divide-by-zero result is whatever the division operators yield. It is architecturally unpredictable and the bench must not check it.

Decomposition:
- Shared package/header macros:
  - md op encodings MD_NONE..MD_MTLO.
  - MULT_CYCLES / DIV_CYCLES defaults.
  - FSM state encodings.
- One natural sub-module, md_calc: purely combinational, computes {HI_s,LO_s} from op and operands. The top level holds the FSM, counter, staging and HI/LO.

Test Plan:
- Reset, then MULT with rs=0xFFFFFFFE (-2), rt=3 -> busy high for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- DIV with rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 -> LO=3, HI=1.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> HI/LO update on the respective edges; busy stays 0.
- MULT started, reset asserted for one cycle at the third busy cycle -> busy=0 and HI=LO=0 at the next cycle; the result is never committed.
- With MD_DIV0_GUARD_EN defined: HI=5, LO=6 preloaded via MTHI/MTLO, then DIV by 0 -> busy for 10 cycles, HI=5 and LO=6 unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: op encodings, default latencies and FSM states for md_unit.
package md_unit_pkg;
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational HI/LO result for MULT/MULTU/DIV/DIVU.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [63:0] mul_s, mul_u;
    logic [31:0] q_s, r_s, q_u, r_u;
    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mul_u = {32'b0, a} * {32'b0, b};
    assign q_s = $signed(a) / $signed(b);
    assign r_s = $signed(a) % $signed(b);
    assign q_u = a / b;
    assign r_u = a % b;
    always_comb begin
        {hi, lo} = op == MD_MULT  ? mul_s :
                   op == MD_MULTU ? mul_u :
                   op == MD_DIV   ? {r_s, q_s} :
                   op == MD_DIVU  ? {r_u, q_u} : 64'b0;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit holding HI/LO, with MTHI/MTLO writes.
// Define MD_DIV0_GUARD_EN to make divide-by-zero leave HI/LO untouched.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    output logic        E_md_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    md_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] hi, lo, hi_s, lo_s, calc_hi, calc_lo;
    logic        is_div, start, commit, div0, skip_s, mt_hi, mt_lo;

    assign is_div = E_md_op == MD_DIV || E_md_op == MD_DIVU;
    assign start  = state == MD_IDLE && E_md_start && (E_md_op == MD_MULT || E_md_op == MD_MULTU || is_div);
    assign commit = state == MD_RUN && cnt == '0;
    assign mt_hi  = state == MD_IDLE && E_md_op == MD_MTHI;
    assign mt_lo  = state == MD_IDLE && E_md_op == MD_MTLO;

`ifdef MD_DIV0_GUARD_EN
    assign div0 = is_div && E_rt_val == 32'b0;
`else
    assign div0 = 1'b0;
`endif

    md_calc u_calc (
        .op (E_md_op),
        .a  (E_rs_val),
        .b  (E_rt_val),
        .hi (calc_hi),
        .lo (calc_lo)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (start) begin
            state_n = MD_RUN;
            cnt_n   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end else if (state == MD_RUN) begin
            state_n = commit ? MD_IDLE : MD_RUN;
            cnt_n   = commit ? cnt : cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi_s   <= '0;
            lo_s   <= '0;
            skip_s <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (start) begin
                hi_s   <= calc_hi;
                lo_s   <= calc_lo;
                skip_s <= div0;
            end
            if (commit && !skip_s) begin
                hi <= hi_s;
                lo <= lo_s;
            end
            if (mt_hi) hi <= E_rs_val;
            if (mt_lo) lo <= E_rs_val;
        end
    end

    // The hazard unit must hold md-class instructions out of E while busy.
    assert property (@(posedge clk) disable iff (reset)
        state == MD_RUN |-> !(E_md_start || E_md_op == MD_MTHI || E_md_op == MD_MTLO));

    assign E_md_busy = state == MD_RUN;
    assign E_HI = hi;
    assign E_LO = lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus for md_unit checked every cycle against a result-scheduling model.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_md_start = 1'b0;
    logic [2:0]  E_md_op = 3'd0;
    logic [31:0] E_rs_val = '0;
    logic [31:0] E_rt_val = '0;
    logic        E_md_busy;
    logic [31:0] E_HI, E_LO;

    int pass_cnt = 0;
    int total_cnt = 0;

    md_unit dut (
        .clk        (clk),
        .reset      (reset),
        .E_md_start (E_md_start),
        .E_md_op    (E_md_op),
        .E_rs_val   (E_rs_val),
        .E_rt_val   (E_rt_val),
        .E_md_busy  (E_md_busy),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: an accepted op schedules its result to land N edges later.
    bit          m_valid = 0;
    int          m_wait = 0;
    bit          m_commit = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk) begin
        int sa, sb;
        longint prod;
        longint unsigned uprod;
        sa = E_rs_val;
        sb = E_rt_val;
        if (reset) begin
            m_valid = 1;
            m_wait = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0 && m_commit) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (E_md_start && E_md_op >= 3'd1 && E_md_op <= 3'd4) begin
            m_commit = 1;
            if (E_md_op == 3'd1) begin
                prod = longint'(sa) * longint'(sb);
                {p_hi, p_lo} = prod;
            end else if (E_md_op == 3'd2) begin
                uprod = longint'(E_rs_val) * longint'(E_rt_val);
                {p_hi, p_lo} = uprod;
            end else if (sb == 0) begin
`ifdef MD_DIV0_GUARD_EN
                m_commit = 0;
`endif
            end else if (E_md_op == 3'd3) begin
                p_lo = sa / sb;
                p_hi = sa % sb;
            end else begin
                p_lo = E_rs_val / E_rt_val;
                p_hi = E_rs_val % E_rt_val;
            end
            m_wait = E_md_op <= 3'd2 ? 5 : 10;
        end else if (E_md_op == 3'd5) m_hi = E_rs_val;
        else if (E_md_op == 3'd6) m_lo = E_rs_val;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy", {31'b0, E_md_busy}, {31'b0, m_wait > 0});
            check("model_hi", E_HI, m_hi);
            check("model_lo", E_LO, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic st);
        @(posedge clk); #1;
        E_md_op = op;
        E_rs_val = rs;
        E_rt_val = rt;
        E_md_start = st;
        @(posedge clk); #1;
        E_md_op = 3'd0;
        E_md_start = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input int n, input logic [31:0] ehi, input logic [31:0] elo);
        int cnt = 0;
        issue(op, rs, rt, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!E_md_busy) break;
            cnt++;
        end
        check({name, "_cycles"}, cnt, n);
        check({name, "_hi"}, E_HI, ehi);
        check({name, "_lo"}, E_LO, elo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, E_md_busy}, 32'd0);
        check("reset_hi", E_HI, 32'h0);
        check("reset_lo", E_LO, 32'h0);

        run("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run("mult_min", 3'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
        run("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run("div_negdiv", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        @(posedge clk); #1;
        E_md_op = 3'd5;
        E_rs_val = 32'h12345678;
        @(posedge clk); #1;
        E_md_op = 3'd6;
        E_rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        check("mthi_hi", E_HI, 32'h12345678);
        check("mthi_lo", E_LO, 32'hFFFFFFFD);
        check("mthi_busy", {31'b0, E_md_busy}, 32'd0);
        @(posedge clk); #1;
        E_md_op = 3'd0;
        @(negedge clk);
        check("mtlo_lo", E_LO, 32'h9ABCDEF0);
        check("mtlo_busy", {31'b0, E_md_busy}, 32'd0);

        issue(3'd1, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, E_md_busy}, 32'd0);
        check("abort_hi", E_HI, 32'h0);
        check("abort_lo", E_LO, 32'h0);
        repeat (8) @(negedge clk);
        check("abort_late_hi", E_HI, 32'h0);
        check("abort_late_lo", E_LO, 32'h0);

        issue(3'd7, 32'd123, 32'd456, 1'b1);
        @(negedge clk);
        check("unknown_busy", {31'b0, E_md_busy}, 32'd0);
        check("unknown_hi", E_HI, 32'h0);

        issue(3'd5, 32'h1, 32'h0, 1'b0);
        run("mult_after", 3'd1, 32'd6, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

`ifdef MD_DIV0_GUARD_EN
        issue(3'd5, 32'd5, 32'd0, 1'b0);
        issue(3'd6, 32'd6, 32'd0, 1'b0);
        run("div0", 3'd3, 32'd9, 32'd0, 10, 32'd5, 32'd6);
        run("divu0", 3'd4, 32'd9, 32'd0, 10, 32'd5, 32'd6);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
